// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Imported by the interface, the ALU and the arbiter top.
package alu_arb_pkg;

    localparam int ALU_OP_W  = 4;
    localparam int WIDTH_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] OP_SLL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] OP_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] OP_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] OP_SLT  = 4'd8;
    localparam logic [ALU_OP_W-1:0] OP_SLTU = 4'd9;
    localparam logic [ALU_OP_W-1:0] OP_PA   = 4'd10;
    localparam logic [ALU_OP_W-1:0] OP_PB   = 4'd11;

endpackage

// File: rtl/alu_arb_if.sv
// Request/response bundle between two requesters and alu_arb.
// master = requester side, slave = arbiter side.
interface alu_arb_if
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic                req0_valid;
    logic                req0_ready;
    logic [WIDTH-1:0]    req0_a;
    logic [WIDTH-1:0]    req0_b;
    logic [ALU_OP_W-1:0] req0_op;
    logic                req1_valid;
    logic                req1_ready;
    logic [WIDTH-1:0]    req1_a;
    logic [WIDTH-1:0]    req1_b;
    logic [ALU_OP_W-1:0] req1_op;
    logic                rsp0_valid;
    logic                rsp0_ready;
    logic [WIDTH-1:0]    rsp0_res;
    logic                rsp1_valid;
    logic                rsp1_ready;
    logic [WIDTH-1:0]    rsp1_res;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_res, rsp1_valid, rsp1_res
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_res, rsp1_valid, rsp1_res
    );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU shared by the arbiter.
// Unused opcodes produce zero.
module alu
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [WIDTH-1:0]    res
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] sh;

    assign sh = b[SHW-1:0];

    // opcode decode
    always_comb begin
        res = '0;
        unique case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLL:  res = a << sh;
            OP_SRL:  res = a >> sh;
            OP_SRA:  res = $signed(a) >>> sh;
            OP_SLT:  res[0] = $signed(a) < $signed(b);
            OP_SLTU: res[0] = a < b;
            OP_PA:   res = a;
            OP_PB:   res = b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// Round-robin arbiter sharing one ALU between two requesters.
// One operation in flight: IDLE -> EXEC -> RESP -> IDLE.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = 2
) (
    input  logic     clk,
    input  logic     rst,
    alu_arb_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    state_t              state, state_nxt;
    logic [IDW-1:0]      ptr, gnt_id, id_q;
    logic [WIDTH-1:0]    a_q, b_q, res_q, alu_res;
    logic [WIDTH-1:0]    gnt_a, gnt_b;
    logic [ALU_OP_W-1:0] op_q, gnt_op;
    logic                any_valid, acc;
    logic                rdy0, rdy1, rv0, rv1;
    logic                v0, v1;

    // pick the requester to serve and mux its operands
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        gnt_id    = ptr;
        if (bus.req0_valid && !bus.req1_valid)
            gnt_id = '0;
        else if (!bus.req0_valid && bus.req1_valid)
            gnt_id = IDW'(1);
        gnt_a  = gnt_id[0] ? bus.req1_a  : bus.req0_a;
        gnt_b  = gnt_id[0] ? bus.req1_b  : bus.req0_b;
        gnt_op = gnt_id[0] ? bus.req1_op : bus.req0_op;
    end

    // next state and handshake outputs
    always_comb begin
        state_nxt = state;
        acc       = 1'b0;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        rv0       = 1'b0;
        rv1       = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    acc       = 1'b1;
                    rdy0      = ~gnt_id[0];
                    rdy1      = gnt_id[0];
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rv0 = ~id_q[0];
                rv1 = id_q[0];
                if (id_q[0] ? bus.rsp1_ready : bus.rsp0_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // reset masks every handshake output, including mid-RESP
    assign v0 = rv0 & ~rst;
    assign v1 = rv1 & ~rst;

    assign bus.req0_ready = rdy0 & ~rst;
    assign bus.req1_ready = rdy1 & ~rst;
    assign bus.rsp0_valid = v0;
    assign bus.rsp1_valid = v1;
    assign bus.rsp0_res   = v0 ? res_q : '0;
    assign bus.rsp1_res   = v1 ? res_q : '0;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .res (alu_res)
    );

    // state, pointer, operand and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            id_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                a_q  <= gnt_a;
                b_q  <= gnt_b;
                op_q <= gnt_op;
                id_q <= gnt_id;
                ptr  <= ~gnt_id;
            end
            if (state == EXEC)
                res_q <= alu_res;
        end
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set operand and result width.
REQ-002 Parameter NREQ, default 2, SHALL set the number of requesters; this revision supports only 2.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) SHALL indicate that requester N presents an operation.
REQ-006 reqN_ready  output  1  SHALL indicate that alu_arb accepts requester N's operation this cycle.
REQ-007 reqN_a, reqN_b  input  WIDTH  SHALL carry the operands.
REQ-008 reqN_op  input  4  SHALL carry the ALU opcode, passed through unmodified.
REQ-009 rspN_valid  output  1  SHALL indicate that the result for requester N is presented.
REQ-010 rspN_ready  input  1  SHALL indicate that requester N consumes the result.
REQ-011 rspN_res  output  WIDTH  SHALL carry the result.

Function
REQ-012 A single alu #(WIDTH) instance SHALL be shared by both requesters.
REQ-013 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-014 In IDLE, reqN_ready SHALL be asserted combinationally for the granted requester only; it SHALL be 0 in EXEC and RESP.
REQ-015 Grant rule: if only one requester is valid, that requester SHALL be granted; if both are valid, the requester indicated by the round-robin pointer SHALL be granted.
REQ-016 The round-robin pointer SHALL toggle to the non-granted requester on every accepted handshake.
REQ-017 Handshake on edge k (IDLE, valid&&ready): a, b, op and the requester id SHALL be latched, and the FSM SHALL go to EXEC.
REQ-018 In EXEC, the ALU SHALL see the latched operands; on edge k+1 its result SHALL be registered into the result register, and the FSM SHALL go to RESP.
REQ-019 In RESP, rspN_valid SHALL be 1 only for the latched requester id, with rspN_res equal to the registered result; the other rsp valid SHALL be 0.
REQ-020 In RESP, the result SHALL hold stable until rspN_ready is sampled high; on that edge the FSM SHALL go to IDLE.
REQ-021 The minimum turnaround from handshake to the next accept SHALL be 3 cycles, and there SHALL be at most one outstanding operation.
REQ-022 A requester deasserting valid before ready SHALL cause no state change.
REQ-023 A valid requester SHALL hold its inputs stable until it receives ready.
REQ-024 rspN_res SHALL be 0 whenever rspN_valid is 0.
REQ-025 Opcode values SHALL NOT be interpreted; any 4-bit op, including unused codes, SHALL complete through the same sequence.

Reset
REQ-026 While rst is high on an edge, the FSM SHALL go to IDLE, the pointer SHALL be 0 (requester 0 preferred), and the latched operands, op, id and result SHALL be 0.
REQ-027 During and after reset, all ready and rsp valid outputs SHALL be 0; reqN_ready SHALL follow REQ-014 from the first cycle after rst deasserts.
REQ-028 A reset in EXEC or RESP SHALL abandon the operation; no response SHALL ever be issued for it.

Structure
REQ-029 Package alu_arb_pkg SHALL hold the state enum (IDLE/EXEC/RESP), the ALU_OP_W=4 constant and the WIDTH default.
REQ-030 The existing alu SHALL be the only sub-module, instantiated once.
REQ-031 The arbitration, FSM and registers SHALL reside in alu_arb itself.

Verification
REQ-032 Single request: req0 a=64'hfffffffffffffff0, b=0, op=4'd8 at cycle 0 -> req0_ready=1 at cycle 0, rsp0_valid=1 at cycle 2, rsp0_res equals standalone alu output for the same inputs, and rsp1_valid stays 0.
REQ-033 Contention: both requesters valid continuously after reset (req0 op=4'd8, req1 op=4'd15) -> grants 0,1,0,1, and each rsp carries its own requester's result.
REQ-034 Backpressure: rsp1_ready held low for 5 cycles in RESP -> rsp1_valid and rsp1_res stay constant, no new grant is given, and IDLE is reached the edge after rsp1_ready rises.
REQ-035 Reset mid-operation: rst high for 1 cycle in EXEC -> no rsp valid is ever asserted for that operation, and the next request is granted to requester 0.
REQ-036 Withdrawn request: req1_valid pulsed for 1 cycle while in RESP for req0 -> no grant is given to requester 1, and the pointer is unchanged.
REQ-037 Random back-to-back stream of 1000 operations -> every response matches the alu reference model, and the minimum spacing between accepts is 3 cycles.
